ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the single-port NBBPU data RAM (256 x 16-bit, registered 1-cycle read) between two requesters: requester 0 is the CPU load/store path and requester 1 is the debug/boot loader.
- Each requester has a valid/ready request channel and a response pulse.
- The arbiter sequences every access as a 2-cycle transaction (ISSUE, RESPOND) and does round-robin arbitration on contention.
- It sits between the requesters and the RAM's select/read_enable/write_enable/address/write_data/read_data pins.

Parameters:
- DATA_WIDTH, 16, data word width.
- ADDR_WIDTH, 16, request/RAM address width.
- RAM_DEPTH, 256, number of implemented RAM words; addresses >= RAM_DEPTH are out of range.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  2  per-requester request valid, bit i = requester i.
- req_write  in  2  per-requester: 1 = write, 0 = read.
- req_address  in  2*ADDR_WIDTH  per-requester address; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_write_data  in  2*DATA_WIDTH  per-requester write data, packed the same way.
- req_ready  out  2  one-hot pulse: the request is accepted this cycle.
- rsp_valid  out  2  one-hot pulse: the response is valid this cycle.
- rsp_data  out  DATA_WIDTH  read data; 0 for writes and errors.
- rsp_error  out  1  the responded request was out of range.
- ram_select, ram_read_enable, ram_write_enable  out  1 each  RAM controls.
- ram_address  out  ADDR_WIDTH  RAM address.
- ram_write_data  out  DATA_WIDTH  RAM write data.
- ram_read_data  in  DATA_WIDTH  RAM registered read data.

Behaviour:
- Reset, when reset==0 at posedge:
  - state=IDLE, last_grant=1 (so requester 0 wins the first tie).
  - rsp_valid=0, rsp_error=0, rsp_data=0.
  - All RAM controls deasserted.
- A reset arriving mid-transaction abandons it: no rsp_valid is issued. A write already clocked into the RAM stays written.
- FSM states: IDLE and RESPOND.
- IDLE:
  - Winner = the only valid requester. If both are valid, the winner is the requester not equal to last_grant.
  - req_ready[winner]=1 combinationally in the same cycle.
  - The RAM is driven combinationally in that cycle:
    - ram_address and ram_write_data come from the winner.
    - ram_read_enable = ~req_write[winner]; ram_write_enable = req_write[winner].
    - ram_select = 1 only if the address is < RAM_DEPTH.
  - At posedge: latch owner=winner, was_read, and err = out-of-range; last_grant=winner; go to RESPOND.
  - With no valid request, stay in IDLE with all outputs low.
- RESPOND (exactly 1 cycle):
  - rsp_valid[owner]=1.
  - rsp_data = ram_read_data if was_read & ~err, else 0.
  - rsp_error=err.
  - req_ready=0 and RAM controls are low.
  - Go to IDLE unconditionally.
- Latency and throughput:
  - Accept at cycle T, response at T+1.
  - Maximum rate is one access per 2 cycles.
  - Back-to-back accesses from the same requester are allowed when the other is idle.
- Handshake rules:
  - A requester holds valid, write, address and data stable until req_ready.
  - Deasserting valid before ready is allowed; the request is simply not taken.
  - req_ready is never asserted without the corresponding req_valid.
- Out of range:
  - The address is compared against RAM_DEPTH using the full ADDR_WIDTH width.
  - An out-of-range request is accepted and responded to normally with rsp_error=1.
  - The RAM is never selected for it, so RAM contents are unchanged.
- Starvation bound: under continuous contention, each requester is granted at least every 4 cycles.

Optional Feature:
- RAM_ARB_FIXED_PRIORITY_EN defined:
  - Requester 0 always wins contention; last_grant is still updated but ignored.
  - Requester 1 can starve.
- Not defined: round-robin as described above.

Decomposition:
- Package nbbpu_ram_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults, and RAM_DEPTH.
  - Requester ID constants REQ_CPU=0 and REQ_LOADER=1.
  - The state enum {IDLE, RESPOND}.
- Sub-module rr_arbiter_2: takes the 2-bit valid vector plus last_grant and outputs the one-hot grant. It contains the fixed-priority ifdef.

Test Plan:
- Single read: after reset, preload RAM[0x10]=0xBEEF; req0 read 0x0010 -> req_ready[0] at T, rsp_valid=2'b01 at T+1, rsp_data=0xBEEF, rsp_error=0.
- Write then read: req1 write 0x0005 with 0x1234, then req1 read 0x0005 -> RAM[5]=0x1234, rsp_data=0x1234 on the second response, rsp_data=0 on the write response.
- Contention: both requests held valid for 8 cycles -> grant order 0,1,0,1 on cycles 0,2,4,6. With RAM_ARB_FIXED_PRIORITY_EN -> 0,0,0,0.
- Out of range: req0 write 0x0100 with 0xFFFF -> ram_select never 1; rsp_error=1, rsp_data=0; RAM[0x00] unchanged.
- Reset mid-operation: accept req0 read at T, reset=0 at T+1 -> no rsp_valid; state IDLE; next tie is granted to requester 0.
- Stability: req1 valid with no contention -> req_ready[1] pulses every 2 cycles, never twice in a row.

Source files
------------

// File: rtl/nbbpu_ram_pkg.sv
// Shared definitions for the NBBPU data-RAM arbiter: default widths, RAM
// depth, requester IDs and the transaction state encoding.
package nbbpu_ram_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 16;
    localparam int DEFAULT_RAM_DEPTH  = 256;

    // Requester identifiers (bit position in the per-requester vectors)
    localparam logic REQ_CPU    = 1'b0;
    localparam logic REQ_LOADER = 1'b1;

    // ISSUE happens in IDLE (request accepted, RAM driven); RESPOND returns data
    typedef enum logic {
        IDLE    = 1'b0,
        RESPOND = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester grant logic. Without RAM_ARB_FIXED_PRIORITY_EN a tie goes to
// the requester that did not win last time; with RAM_ARB_FIXED_PRIORITY_EN
// defined, requester 0 always wins a tie and last_grant is ignored.
module rr_arbiter_2
    import nbbpu_ram_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifdef RAM_ARB_FIXED_PRIORITY_EN
    // last_grant is still tracked by the parent but plays no part here
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // One-hot grant: a lone requester always wins, ties are resolved below
    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
`ifdef RAM_ARB_FIXED_PRIORITY_EN
                grant = 2'b01;
`else
                grant = (last_grant == REQ_LOADER) ? 2'b01 : 2'b10;
`endif
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port NBBPU data RAM (registered 1-cycle read) between the
// CPU load/store path (requester 0) and the debug/boot loader (requester 1).
// Every access is a 2-cycle transaction: the request is accepted and the RAM
// driven in IDLE, the response is returned in RESPOND.
// Handshake: a requester holds req_valid/req_write/req_address/
// req_write_data stable until it sees req_ready (a one-cycle pulse, only ever
// with its own req_valid high); dropping req_valid earlier withdraws the
// request. rsp_valid pulses one-hot exactly one cycle after req_ready.
// Build option: RAM_ARB_FIXED_PRIORITY_EN (requester 0 always wins ties).
module ram_arbiter
    import nbbpu_ram_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int RAM_DEPTH  = DEFAULT_RAM_DEPTH
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                req_valid,
    input  logic [1:0]                req_write,
    input  logic [2*ADDR_WIDTH-1:0]   req_address,
    input  logic [2*DATA_WIDTH-1:0]   req_write_data,
    output logic [1:0]                req_ready,
    output logic [1:0]                rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_data,
    output logic                      rsp_error,
    output logic                      ram_select,
    output logic                      ram_read_enable,
    output logic                      ram_write_enable,
    output logic [ADDR_WIDTH-1:0]     ram_address,
    output logic [DATA_WIDTH-1:0]     ram_write_data,
    input  logic [DATA_WIDTH-1:0]     ram_read_data,
    output state_t                    debug_state
);

    // One extra bit so a RAM_DEPTH equal to 2**ADDR_WIDTH still compares correctly
    localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    state_t state;
    state_t state_next;

    logic   last_grant;
    logic   owner;
    logic   was_read;
    logic   err;

    logic [1:0]            grant;
    logic                  any_grant;
    logic                  winner;
    logic                  win_write;
    logic [ADDR_WIDTH-1:0] win_address;
    logic [DATA_WIDTH-1:0] win_write_data;
    logic                  win_in_range;

    rr_arbiter_2 u_arbiter (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign any_grant      = |grant;
    assign winner         = grant[1];
    assign win_write      = winner ? req_write[1] : req_write[0];
    assign win_address    = winner ? req_address[ADDR_WIDTH +: ADDR_WIDTH]
                                   : req_address[0 +: ADDR_WIDTH];
    assign win_write_data = winner ? req_write_data[DATA_WIDTH +: DATA_WIDTH]
                                   : req_write_data[0 +: DATA_WIDTH];
    assign win_in_range   = ({1'b0, win_address} < DEPTH_LIMIT);

    assign debug_state = state;

    // Transaction state plus the facts about the accepted request needed to respond
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= REQ_LOADER;
            owner      <= REQ_CPU;
            was_read   <= 1'b0;
            err        <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_grant) begin
                owner      <= winner;
                was_read   <= ~win_write;
                err        <= ~win_in_range;
                last_grant <= winner;
            end
        end
    end

    // Next state, handshake pulses, response and RAM pin drive
    always_comb begin
        state_next       = state;
        req_ready        = 2'b00;
        rsp_valid        = 2'b00;
        rsp_data         = '0;
        rsp_error        = 1'b0;
        ram_select       = 1'b0;
        ram_read_enable  = 1'b0;
        ram_write_enable = 1'b0;
        ram_address      = '0;
        ram_write_data   = '0;
        case (state)
            IDLE: begin
                if (any_grant) begin
                    req_ready        = grant;
                    ram_address      = win_address;
                    ram_write_data   = win_write_data;
                    ram_read_enable  = ~win_write;
                    ram_write_enable = win_write;
                    // Out-of-range requests never touch the RAM
                    ram_select       = win_in_range;
                    state_next       = RESPOND;
                end
            end
            RESPOND: begin
                rsp_valid  = owner ? 2'b10 : 2'b01;
                rsp_data   = (was_read && !err) ? ram_read_data : '0;
                rsp_error  = err;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural registered-read RAM.
// Expected responses are queued when a request is accepted; a monitor pops
// and compares whenever rsp_valid is seen.
module tb_ram_arbiter;
    import nbbpu_ram_pkg::*;

    localparam int DW = 16;
    localparam int AW = 16;

    logic            clock;
    logic            reset;
    logic [1:0]      req_valid;
    logic [1:0]      req_write;
    logic [2*AW-1:0] req_address;
    logic [2*DW-1:0] req_write_data;
    logic [1:0]      req_ready;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic            rsp_error;
    logic            ram_select;
    logic            ram_read_enable;
    logic            ram_write_enable;
    logic [AW-1:0]   ram_address;
    logic [DW-1:0]   ram_write_data;
    logic [DW-1:0]   ram_read_data;
    state_t          debug_state;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {requester id, error, data}
    logic [DW+1:0] exp_q[$];

    logic [DW-1:0] mem [256];

    ram_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_address      (req_address),
        .req_write_data   (req_write_data),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_error        (rsp_error),
        .ram_select       (ram_select),
        .ram_read_enable  (ram_read_enable),
        .ram_write_enable (ram_write_enable),
        .ram_address      (ram_address),
        .ram_write_data   (ram_write_data),
        .ram_read_data    (ram_read_data),
        .debug_state      (debug_state)
    );

    // Clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Behavioural single-port RAM, registered read
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h00] = 16'hA5A5;
        mem[8'h10] = 16'hBEEF;
        mem[8'hFF] = 16'h5A5A;
        ram_read_data = '0;
    end

    always @(posedge clock) begin
        if (ram_select) begin
            if (ram_write_enable) mem[ram_address[7:0]] <= ram_write_data;
            if (ram_read_enable)  ram_read_data <= mem[ram_address[7:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response must match the oldest queued expectation
    always @(negedge clock) begin
        if (rsp_valid !== 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
            end else begin
                logic [DW+1:0] e;
                e = exp_q.pop_front();
                chk("rsp_valid", {30'd0, rsp_valid}, e[DW+1] ? 32'd2 : 32'd1);
                chk("rsp_error", {31'd0, rsp_error}, {31'd0, e[DW]});
                chk("rsp_data", {16'd0, rsp_data}, {16'd0, e[DW-1:0]});
            end
        end
    end

    // Single request from one requester; waits for acceptance and queues the response
    task automatic do_req(input int id, input logic wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input logic [DW-1:0] exp_d,
                          input logic exp_e, input logic exp_sel);
        logic got;
        logic [1:0] exp_r;
        exp_r = (id == 1) ? 2'b10 : 2'b01;
        @(posedge clock); #1;
        req_valid = 2'b00;
        req_valid[id] = 1'b1;
        req_write[id] = wr;
        req_address[id*AW +: AW] = addr;
        req_write_data[id*DW +: DW] = wd;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clock);
            if (req_ready != 2'b00) got = 1'b1;
        end
        chk("accept_timeout", {31'd0, got}, 32'd1);
        if (got) begin
            chk("req_ready", {30'd0, req_ready}, {30'd0, exp_r});
            chk("ram_select", {31'd0, ram_select}, {31'd0, exp_sel});
            chk("ram_write_enable", {31'd0, ram_write_enable}, {31'd0, wr});
            if (exp_sel) chk("ram_address", {16'd0, ram_address}, {16'd0, addr});
            exp_q.push_back({id[0], exp_e, exp_d});
        end
        @(posedge clock); #1;
        req_valid = 2'b00;
    endtask

    logic [1:0] exp_grant [8];

    initial begin
`ifdef RAM_ARB_FIXED_PRIORITY_EN
        exp_grant = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
`else
        exp_grant = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
`endif
        reset          = 1'b0;
        req_valid      = '0;
        req_write      = '0;
        req_address    = '0;
        req_write_data = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_ready", {30'd0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("reset_rsp_error", {31'd0, rsp_error}, 32'd0);
        chk("reset_ram_select", {31'd0, ram_select}, 32'd0);
        chk("reset_state", {31'd0, debug_state}, {31'd0, IDLE});
        @(posedge clock); #1;
        reset = 1'b1;

        // Single read
        do_req(0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 1'b1);
        // Write then read from the loader
        do_req(1, 1'b1, 16'h0005, 16'h1234, 16'h0000, 1'b0, 1'b1);
        do_req(1, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0, 1'b1);
        chk("mem5_written", {16'd0, mem[8'h05]}, 32'h1234);
        // Out of range write, then confirm RAM[0] untouched
        do_req(0, 1'b1, 16'h0100, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        do_req(0, 1'b0, 16'h0000, 16'h0000, 16'hA5A5, 1'b0, 1'b1);
        chk("mem0_unchanged", {16'd0, mem[8'h00]}, 32'hA5A5);
        // Highest in-range address, and an out-of-range read with high bits set
        do_req(1, 1'b0, 16'h00FF, 16'h0000, 16'h5A5A, 1'b0, 1'b1);
        do_req(1, 1'b0, 16'h8010, 16'h0000, 16'h0000, 1'b1, 1'b0);

        // Contention after a fresh reset: both hold reads for 8 cycles
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        req_write = 2'b00;
        req_address = {16'h0005, 16'h0010};
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk($sformatf("contention_grant%0d", i), {30'd0, req_ready}, {30'd0, exp_grant[i]});
            if (req_ready == 2'b01) exp_q.push_back({1'b0, 1'b0, 16'hBEEF});
            if (req_ready == 2'b10) exp_q.push_back({1'b1, 1'b0, 16'h1234});
            @(posedge clock); #1;
        end
        req_valid = 2'b00;

        // Reset arriving as a read is accepted: the transaction is abandoned
        @(posedge clock); #1;
        req_write[0] = 1'b0;
        req_address[0 +: AW] = 16'h0010;
        req_valid = 2'b01;
        reset = 1'b0;
        @(negedge clock);
        chk("abandon_ready", {30'd0, req_ready}, 32'd1);
        @(posedge clock); #1;
        req_valid = 2'b00;
        reset = 1'b1;
        @(negedge clock);
        chk("abandon_no_rsp", {30'd0, rsp_valid}, 32'd0);
        chk("abandon_state", {31'd0, debug_state}, {31'd0, IDLE});
        // Next tie goes to requester 0
        @(posedge clock); #1;
        req_address = {16'h0005, 16'h0010};
        req_valid = 2'b11;
        @(negedge clock);
        chk("post_reset_tie", {30'd0, req_ready}, 32'd1);
        if (req_ready == 2'b01) exp_q.push_back({1'b0, 1'b0, 16'hBEEF});
        @(posedge clock); #1;
        req_valid = 2'b00;

        // Lone loader held valid: ready every other cycle
        @(posedge clock); #1;
        req_address[AW +: AW] = 16'h0005;
        req_valid = 2'b10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            chk($sformatf("stream_ready%0d", i), {30'd0, req_ready}, (i % 2 == 0) ? 32'd2 : 32'd0);
            if (req_ready == 2'b10) exp_q.push_back({1'b1, 1'b0, 16'h1234});
            @(posedge clock); #1;
        end
        req_valid = 2'b00;

        for (int c = 0; c < 10 && exp_q.size() != 0; c++) @(posedge clock);
        @(negedge clock);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
